// File: rtl/pc_seq_unit.sv
// Program-counter unit: owns the PC register, next-PC select, misaligned-target trap
// and a one-entry buffer that keeps a redirect issued during a stall until the stall lifts.

module pc_seq_unit_chk #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0100,
    parameter logic [XLEN-1:0]      ALIGN_MASK   = 32'h0000_0003
) (
    input logic            clk,
    input logic            rst_n,
    input logic [XLEN-1:0] pc_o,
    input logic            misalign_o
);
    a_vec_align: assert property (@(posedge clk)
        ((RESET_VECTOR & ALIGN_MASK) == '0) && ((TRAP_VECTOR & ALIGN_MASK) == '0));

    a_mis_trap: assert property (@(posedge clk) disable iff (!rst_n)
        misalign_o |-> (pc_o == TRAP_VECTOR));
endmodule

module pc_seq_unit #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] alu_target,
    input  logic [XLEN-1:0] pc_imm,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misalign_o,
    output logic            hold_valid_o
);
    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

    localparam logic [1:0]      SEL_REG    = 2'b00;
    localparam logic [1:0]      SEL_SEQ    = 2'b01;
    localparam logic [1:0]      SEL_REL    = 2'b10;
    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(32'd1) << ALIGN_BITS) - XLEN'(32'd1);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d;
    logic            misalign_q, misalign_d, hold_valid_q;
    logic [XLEN-1:0] hold_tgt_q, hold_tgt_d, hold_pc_q, hold_pc_d;
    logic            hold_mis_q, hold_mis_d;
    logic [XLEN-1:0] pc4_s, target_s, take_tgt_s, take_pc_s;
    logic            mis_s, take_s, take_mis_s;

    // Only register and PC-relative targets can be misaligned; bit 0 is already cleared for JALR.
    function automatic logic is_misaligned(input logic [1:0] s, input logic [XLEN-1:0] t);
        logic redirect;
        redirect = (s == SEL_REG) || (s == SEL_REL);
        return redirect && ((t & ALIGN_MASK) != '0);
    endfunction

    // Candidate target for the current sel and its alignment status.
    always_comb begin
        pc4_s = pc_q + XLEN'(32'd4);
        case (sel)
            SEL_REG: target_s = alu_target & ~XLEN'(32'd1);
            SEL_SEQ: target_s = pc4_s;
            SEL_REL: target_s = pc_imm;
            default: target_s = TRAP_VECTOR;
        endcase
        mis_s = is_misaligned(sel, target_s);
    end

    // RUN/HOLD control: decides whether the PC moves this cycle and with which redirect.
    always_comb begin
        state_d    = state_q;
        hold_tgt_d = hold_tgt_q;
        hold_mis_d = hold_mis_q;
        hold_pc_d  = hold_pc_q;
        take_s     = 1'b0;
        take_tgt_s = target_s;
        take_mis_s = mis_s;
        take_pc_s  = pc_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    take_s = 1'b1;
                end else if (sel != SEL_SEQ) begin
                    hold_tgt_d = target_s;
                    hold_mis_d = mis_s;
                    hold_pc_d  = pc_q;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    take_s     = 1'b1;
                    take_tgt_s = hold_tgt_q;
                    take_mis_s = hold_mis_q;
                    take_pc_s  = hold_pc_q;
                    hold_tgt_d = '0;
                    hold_mis_d = 1'b0;
                    hold_pc_d  = '0;
                    state_d    = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Apply the chosen redirect; a misaligned one diverts to the trap vector.
    always_comb begin
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        if (take_s) begin
            if (take_mis_s) begin
                pc_d       = TRAP_VECTOR;
                epc_d      = take_pc_s;
                misalign_d = 1'b1;
            end else begin
                pc_d = take_tgt_s;
            end
        end else begin
            pc_d = pc_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            misalign_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_tgt_q   <= '0;
            hold_mis_q   <= 1'b0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            misalign_q   <= misalign_d;
            hold_valid_q <= (state_d == ST_HOLD);
            hold_tgt_q   <= hold_tgt_d;
            hold_mis_q   <= hold_mis_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc4_o        = pc4_s;
    assign epc_o        = epc_q;
    assign misalign_o   = misalign_q;
    assign hold_valid_o = hold_valid_q;

    pc_seq_unit_chk #(
        .XLEN(XLEN), .RESET_VECTOR(RESET_VECTOR), .TRAP_VECTOR(TRAP_VECTOR), .ALIGN_MASK(ALIGN_MASK)
    ) u_chk (
        .clk(clk), .rst_n(rst_n), .pc_o(pc_q), .misalign_o(misalign_q)
    );
endmodule
